// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one single-port word memory between the debug
// loader (DBG), the MEM-stage data port (DAT) and the IF-stage fetch (IFE).
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk1,
  input  logic          rst_n,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,

  input  logic          dat_req,
  input  logic          dat_we,
  input  logic [AW-1:0] dat_addr,
  input  logic [DW-1:0] dat_wdata,

  input  logic          ife_req,
  input  logic [AW-1:0] ife_addr,

  output logic          dbg_gnt,
  output logic          dat_gnt,
  output logic          ife_gnt,
  output logic          dbg_rvalid,
  output logic          dat_rvalid,
  output logic          ife_rvalid,
  output logic [DW-1:0] rdata,
  output logic          locked,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       dbg_rv_q, dbg_rv_d;
  logic       dat_rv_q, dat_rv_d;
  logic       ife_rv_q, ife_rv_d;

  logic       w_force_ife;

  // IFE overrides DAT (never DBG) once it has been denied STARVE_LIMIT cycles
  assign w_force_ife = (starve_q == c_starve_max) && ife_req;

  always_comb begin
    dbg_gnt = 1'b0;
    dat_gnt = 1'b0;
    ife_gnt = 1'b0;
    state_d = state_q;
    if (state_q == ST_LOCKED) begin
      dbg_gnt = dbg_req;
      if (!dbg_lock) begin
        state_d = ST_ARB;
      end
    end else begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
        if (dbg_lock) begin
          state_d = ST_LOCKED;
        end
      end else if (w_force_ife) begin
        ife_gnt = 1'b1;
      end else if (dat_req) begin
        dat_gnt = 1'b1;
      end else if (ife_req) begin
        ife_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = dbg_gnt | dat_gnt | ife_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (dat_gnt) begin
      mem_we    = dat_we;
      mem_addr  = dat_addr;
      mem_wdata = dat_wdata;
    end else if (ife_gnt) begin
      mem_addr  = ife_addr;
    end
  end

  // The starvation counter is frozen while DBG owns the port.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_ARB) begin
      if (ife_gnt || !ife_req) begin
        starve_d = 4'd0;
      end else if (starve_q < c_starve_max) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_comb begin
    dbg_rv_d = dbg_gnt & ~dbg_we;
    dat_rv_d = dat_gnt & ~dat_we;
    ife_rv_d = ife_gnt;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ARB;
      starve_q <= 4'd0;
      dbg_rv_q <= 1'b0;
      dat_rv_q <= 1'b0;
      ife_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      dbg_rv_q <= dbg_rv_d;
      dat_rv_q <= dat_rv_d;
      ife_rv_q <= ife_rv_d;
    end
  end

  // The response tag is the one-hot set of rvalid flops; rdata is zero otherwise.
  assign dbg_rvalid = dbg_rv_q;
  assign dat_rvalid = dat_rv_q;
  assign ife_rvalid = ife_rv_q;
  assign rdata      = (dbg_rv_q | dat_rv_q | ife_rv_q) ? mem_rdata : '0;
  assign locked     = (state_q == ST_LOCKED);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified word memory of the pipe_mips32 core between three requesters: the debug/program loader (DBG), the MEM-stage data port (DAT) and the IF-stage fetch port (IFE).
- One access is issued per cycle, with a read response one cycle later.
- Arbitration is fixed-priority with an anti-starvation override for IFE.
- A LOCKED state gives DBG exclusive ownership for bulk program load and result readback.

Parameters:
- AW, 10, word-address width (memory depth 2**AW words)
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive denied IFE request cycles before IFE is forced to win; legal range 1..15

Ports:
- clk1  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- dbg_req, dat_req, ife_req  in  1 each  access request; held until the matching gnt
- dbg_we, dat_we  in  1 each  1 = write, 0 = read; IFE is always a read
- dbg_addr, dat_addr, ife_addr  in  AW each  word address
- dbg_wdata, dat_wdata  in  DW each  write data
- dbg_lock  in  1  DBG requests exclusive ownership
- dbg_gnt, dat_gnt, ife_gnt  out  1 each  request accepted this cycle; combinational, at most one high per cycle
- dbg_rvalid, dat_rvalid, ife_rvalid  out  1 each  read data valid; registered
- rdata  out  DW  read data shared by all requesters; qualify with the per-requester rvalid
- locked  out  1  arbiter is in the LOCKED state
- mem_en, mem_we  out  1 each  memory strobe and write enable; mem_en equals the OR of the gnts
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid the cycle after mem_en with mem_we = 0

Behaviour:
- Reset values:
  - state = ARB; starve_cnt = 0; all rvalid = 0; locked = 0
  - rdata = 0; response tag = none
  - With no requests, all gnts and mem_en are 0, and mem_addr/mem_wdata are 0.
- State ARB:
  - Priority order is DBG > DAT > IFE.
  - Exception: when starve_cnt == STARVE_LIMIT and ife_req = 1, IFE wins over DAT. DBG still wins.
  - The winner's gnt goes high and its address, data and we are muxed onto the mem_* outputs in the same cycle.
  - A request with req = 0 is never granted.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle ife_req = 1 and ife_gnt = 0.
  - Clears on ife_gnt, and on any cycle with ife_req = 0.
- Transition ARB -> LOCKED: on a cycle where dbg_gnt = 1 and dbg_lock = 1. locked goes high the next cycle.
- State LOCKED:
  - Only DBG can be granted; DAT and IFE gnts are forced to 0 and their requests wait.
  - starve_cnt is frozen.
  - Returns to ARB on the first cycle dbg_lock = 0, sampled at the clock edge. Normal arbitration applies in the first cycle after return.
- Read response:
  - A granted read registers a tag for its requester.
  - The next cycle, that requester's rvalid = 1 and rdata = mem_rdata (combinational pass-through of the registered-tag cycle).
  - rvalid is a 1-cycle pulse. Writes produce no rvalid.
- Throughput: back-to-back grants every cycle are legal. A response for the grant in cycle t and a new grant in cycle t+1 coexist.
- Simultaneous events:
  - If dbg_lock deasserts in the same cycle as a DBG grant, that grant completes and the state goes to ARB.
  - If rst_n asserts mid-access, the pending rvalid is discarded and no response is emitted after reset.
- The arbiter holds no write buffering. Memory write ordering equals grant ordering.

Test Plan:
- Reset then idle: rst_n = 0 for 3 cycles -> all gnt/rvalid/locked/mem_en = 0. Release with no requests -> outputs stay 0.
- DBG locked load: dbg_lock = 1, write Mem[0..9] with the factorial program words (e.g. 32'h280a00c8 ...) and Mem[200] = 7, while dat_req/ife_req are held high -> 11 dbg_gnt pulses, zero DAT/IFE gnts. Drop dbg_lock -> locked = 0 next cycle.
- Priority: dbg, dat and ife requests together in ARB -> dbg_gnt. Next cycle with only dat and ife -> dat_gnt. A read of Mem[200] returns 7 with dat_rvalid exactly one cycle after the grant.
- Anti-starvation (STARVE_LIMIT = 4): dat_req and ife_req held continuously -> grant pattern DAT×4 then IFE, repeating. IFE is never denied more than 4 cycles in a row.
- Back-to-back reads: IFE alone reads addresses 0,1,2 on consecutive cycles -> ife_rvalid high for 3 consecutive cycles with rdata = 32'h280a00c8, 32'h28020001, 32'h21430000.
- Reset mid-read: grant a DAT read at cycle t, assert rst_n low before edge t+1 -> dat_rvalid stays 0; after release, state = ARB and starve_cnt = 0.
